// File: rtl/weight_fetch_engine_pkg.sv
// rtl/weight_fetch_engine_pkg.sv - shared EPU types and widths for the weight fetch engine
//
// Purpose: state encoding and default bus widths for the weight-buffer requester.
// Ports:   none (package).

// Fallback for builds that do not pull in the CPU definition header first.
`ifndef WRITE_DIS
`define WRITE_DIS 1'b1
`endif

package weight_fetch_engine_pkg;

    localparam int WEIGHT_ADDR_W = 17;
    localparam int WEIGHT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } weight_fetch_state_t;

endpackage

// File: rtl/weight_fetch_fifo.sv
// rtl/weight_fetch_fifo.sv - small synchronous in-order buffer for fetched weight words
//
// Purpose: DEPTH x WIDTH FIFO; push and pop may coincide at any occupancy.
// Ports:   clk, rst (async active-high)
//          push_i/din_i   write side
//          pop_i/dout_o   read side, dout_o is the head word (0 when empty)
//          count_o, full_o, empty_o  occupancy status

module weight_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees the head slot in the same edge, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/weight_fetch_engine.sv
// rtl/weight_fetch_engine.sv - weight SRAM read initiator streaming words to the conv datapath
//
// Purpose: on start, reads len consecutive words from base and streams them in order.
// Ports:   clk, rst (async active-high)
//          start_i, base_addr_i, len_i        transfer request (sampled in IDLE)
//          busy_o, done_o                     transfer status
//          mem_cs_o, mem_oe_o, mem_addr_o     SRAM read issue / data strobes
//          mem_W_req_o, mem_W_data_o          write side, permanently disabled
//          mem_R_data_i                       SRAM read data
//          w_valid_o, w_data_o, w_ready_i     output stream

module weight_fetch_engine
    import weight_fetch_engine_pkg::*;
#(
    parameter int ADDR_W     = WEIGHT_ADDR_W,
    parameter int DATA_W     = WEIGHT_DATA_W,
    parameter int LEN_W      = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_cs_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_W_req_o,
    output logic [DATA_W-1:0] mem_W_data_o,
    input  logic [DATA_W-1:0] mem_R_data_i,
    output logic              w_valid_o,
    output logic [DATA_W-1:0] w_data_o,
    input  logic              w_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    weight_fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;           // next address to issue
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d; // address of the most recent issue
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    accepted_q, accepted_d;
    logic                inflight_q, inflight_d;
    logic                zero_done_q, zero_done_d;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W:0]      occupancy;
    logic                issue;
    logic                pop;

    // Credits count the word still on the SRAM data bus, so a push can never find the buffer full.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = (state_q == FETCH) && (issued_q != len_q) && !fifo_full
                    && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign pop       = w_valid_o && w_ready_i;

    assign w_valid_o    = !fifo_empty;
    assign mem_cs_o     = issue;
    assign mem_oe_o     = inflight_q;
    assign mem_addr_o   = issue ? addr_q : last_addr_q;
    assign mem_W_req_o  = `WRITE_DIS;
    assign mem_W_data_o = '0;
    assign busy_o       = (state_q != IDLE) || zero_done_q;
    assign done_o       = (state_q == DONE) || zero_done_q;

    weight_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (mem_R_data_i),
        .pop_i   (pop),
        .dout_o  (w_data_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        accepted_d  = accepted_q + LEN_W'(pop);
        inflight_d  = issue;
        zero_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d      = len_i;
                        addr_d     = base_addr_i;
                        issued_d   = '0;
                        accepted_d = '0;
                        state_d    = FETCH;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    issued_d    = issued_q + LEN_W'(1);
                    addr_d      = addr_q + ADDR_W'(1);
                    last_addr_d = addr_q;
                end
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && fifo_empty && (accepted_q == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            accepted_q  <= accepted_d;
            inflight_q  <= inflight_d;
            zero_done_q <= zero_done_d;
        end
    end

endmodule

// File: tb/tb_weight_fetch_engine.sv
// tb/tb_weight_fetch_engine.sv - directed self-checking bench for weight_fetch_engine

`ifndef WRITE_DIS
`define WRITE_DIS 1'b1
`endif

module tb_weight_fetch_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [16:0] base_addr_i = '0;
    logic [16:0] len_i = '0;
    logic        busy_o, done_o, mem_cs_o, mem_oe_o, mem_W_req_o;
    logic [16:0] mem_addr_o;
    logic [31:0] mem_W_data_o, mem_R_data_i, w_data_o;
    logic        w_valid_o;
    logic        w_ready_i = 1'b1;

    int total = 0;
    int bad   = 0;

    weight_fetch_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_cs_o     (mem_cs_o),
        .mem_oe_o     (mem_oe_o),
        .mem_addr_o   (mem_addr_o),
        .mem_W_req_o  (mem_W_req_o),
        .mem_W_data_o (mem_W_data_o),
        .mem_R_data_i (mem_R_data_i),
        .w_valid_o    (w_valid_o),
        .w_data_o     (w_data_o),
        .w_ready_i    (w_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wexp(input logic [16:0] a);
        return 32'hA000_0000 + {15'b0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_cs_o) mem_rdata_upd();
    end
    task automatic mem_rdata_upd();
        mem_R_data_i <= wexp(mem_addr_o);
    endtask

    logic [16:0] addr_log[$];
    logic [31:0] rx_log[$];
    int          cs_cyc[$];
    int          cyc = 0;
    int          cs_cnt = 0;
    int          done_cnt = 0;
    int          occ = 0;
    int          max_occ = 0;
    int          oe_viol = 0;
    logic        prev_cs = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            occ     = 0;
            prev_cs = 1'b0;
        end else begin
            if (mem_oe_o !== prev_cs) begin
                oe_viol++;
                $error("FAIL oe_follows_cs observed=%0h expected=%0h", mem_oe_o, prev_cs);
            end
            prev_cs = mem_cs_o;
            if (mem_cs_o) begin
                addr_log.push_back(mem_addr_o);
                cs_cyc.push_back(cyc);
                cs_cnt++;
            end
            if (done_o) done_cnt++;
            if (w_valid_o && w_ready_i) rx_log.push_back(w_data_o);
            occ = occ + int'(mem_oe_o) - int'(w_valid_o && w_ready_i);
            if (occ > max_occ) max_occ = occ;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        addr_log.delete();
        rx_log.delete();
        cs_cyc.delete();
        cs_cnt   = 0;
        done_cnt = 0;
        max_occ  = 0;
        oe_viol  = 0;
    endtask

    task automatic start(input logic [16:0] base, input logic [16:0] len);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (rnd) w_ready_i = 1'($urandom_range(0, 1));
            tick();
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_seq(input string tag, input logic [16:0] base, input int n);
        logic [16:0] a;
        chk({tag, "_rx_len"}, rx_log.size(), n);
        chk({tag, "_addr_len"}, addr_log.size(), n);
        for (int i = 0; i < n && i < rx_log.size(); i++) begin
            a = base + 17'(i);
            total++;
            if (rx_log[i] !== wexp(a)) begin
                bad++;
                $error("FAIL %s_data observed=%0h expected=%0h", tag, rx_log[i], wexp(a));
            end
        end
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            a = base + 17'(i);
            total++;
            if (addr_log[i] !== a) begin
                bad++;
                $error("FAIL %s_addr observed=%0h expected=%0h", tag, addr_log[i], a);
            end
        end
    endtask

    initial begin
        bit seen;

        tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_cs", mem_cs_o, 1'b0);
        chk("rst_oe", mem_oe_o, 1'b0);
        chk("rst_valid", w_valid_o, 1'b0);
        chk("rst_addr", mem_addr_o, 17'h0);
        chk("rst_wdata", w_data_o, 32'h0);
        chk("rst_wreq", mem_W_req_o, `WRITE_DIS);
        chk("rst_wdat", mem_W_data_o, 32'h0);
        rst = 1'b0;
        tick();
        clr();

        chk("t1_busy_pre", busy_o, 1'b0);
        start(17'h10, 17'd8);
        chk("t1_busy_start1", busy_o, 1'b1);
        chk("t1_cs_first", mem_cs_o, 1'b1);
        chk("t1_addr_first", mem_addr_o, 17'h10);
        wait_done(100, 1'b0, seen);
        chk("t1_done_seen", seen, 1'b1);
        chk("t1_busy_at_done", busy_o, 1'b1);
        check_seq("t1", 17'h10, 8);
        if (cs_cyc.size() == 8) begin
            chk("t1_cs_consecutive", cs_cyc[7] - cs_cyc[0], 7);
        end else begin
            chk("t1_cs_count", cs_cyc.size(), 8);
        end
        tick();
        chk("t1_busy_after", busy_o, 1'b0);
        chk("t1_done_after", done_o, 1'b0);
        chk("t1_done_cnt", done_cnt, 1);
        clr();

        w_ready_i = 1'b0;
        start(17'h10, 17'd8);
        for (int i = 0; i < 20; i++) tick();
        chk("t2_issues", cs_cnt, 4);
        chk("t2_cs_low", mem_cs_o, 1'b0);
        chk("t2_valid", w_valid_o, 1'b1);
        chk("t2_head", w_data_o, 32'hA000_0010);
        chk("t2_addr_hold", mem_addr_o, 17'h13);
        w_ready_i = 1'b1;
        wait_done(100, 1'b0, seen);
        chk("t2_done_seen", seen, 1'b1);
        check_seq("t2", 17'h10, 8);
        tick();
        chk("t2_done_cnt", done_cnt, 1);
        clr();

        start(17'h300, 17'd100);
        wait_done(3000, 1'b1, seen);
        chk("t3_done_seen", seen, 1'b1);
        check_seq("t3", 17'h300, 100);
        chk("t3_max_occ_le4", (max_occ <= 4), 1'b1);
        chk("t3_oe_follows_cs", oe_viol, 0);
        w_ready_i = 1'b1;
        tick();
        chk("t3_done_cnt", done_cnt, 1);
        clr();

        start(17'h55, 17'd0);
        chk("t4_zero_done", done_o, 1'b1);
        chk("t4_zero_cs", mem_cs_o, 1'b0);
        tick();
        chk("t4_zero_done_off", done_o, 1'b0);
        tick();
        chk("t4_zero_no_cs", cs_cnt, 0);
        chk("t4_zero_done_cnt", done_cnt, 1);
        clr();

        start(17'h1FFFE, 17'd4);
        wait_done(100, 1'b0, seen);
        chk("t4_wrap_done", seen, 1'b1);
        check_seq("t4w", 17'h1FFFE, 4);
        tick();
        clr();

        start(17'h40, 17'd6);
        tick();
        start(17'h1000, 17'd2);
        wait_done(100, 1'b0, seen);
        chk("t5_done_seen", seen, 1'b1);
        check_seq("t5", 17'h40, 6);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_cs_cnt", cs_cnt, 6);
        clr();

        start(17'h80, 17'd16);
        for (int i = 0; i < 100 && rx_log.size() < 3; i++) tick();
        chk("t6_rx_before_rst", rx_log.size(), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_cs", mem_cs_o, 1'b0);
        chk("t6_oe", mem_oe_o, 1'b0);
        chk("t6_valid", w_valid_o, 1'b0);
        chk("t6_data", w_data_o, 32'h0);
        chk("t6_addr", mem_addr_o, 17'h0);
        chk("t6_done", done_o, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_done", done_cnt, 0);
        clr();
        start(17'h200, 17'd5);
        wait_done(100, 1'b0, seen);
        chk("t6_new_done", seen, 1'b1);
        check_seq("t6n", 17'h200, 5);
        tick();
        chk("t6_new_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
